// File: rtl/tjmono_ro_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tjmono_ro_pkg                                                              |
// | Shared state encoding, counter widths and helpers for the readout sequencer|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package tjmono_ro_pkg;

    localparam int CNT_W   = 16;
    localparam int PHASE_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_RD_LO = 3'd3;
    localparam logic [2:0] ST_POST  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        PRE   = ST_PRE,
        RD_HI = ST_RD_HI,
        RD_LO = ST_RD_LO,
        POST  = ST_POST
    } state_t;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Combinational round-robin search: first set request after the pointer.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick #(
    parameter int NCH   = 2,
    parameter int IDX_W = 1
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] sel
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_v;
        valid = 1'b0;
        sel   = '0;
        idx   = 0;
        idx_v = '0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int i = NCH; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            idx_v = IDX_W'(idx);
            if (req[idx_v]) begin
                valid = 1'b1;
                sel   = idx_v;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tjmono_ro_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tjmono_ro_sched                                                            |
// | Token-driven FREEZE/READ sequencer sharing one readout path between halves.|
// | Optional per-half burst counters: define TJMONO_RO_SCHED_STATS_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tjmono_ro_sched
    import tjmono_ro_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int FREEZE_PRE  = 4,
    parameter int READ_HI     = 1,
    parameter int READ_LO     = 3,
    parameter int FREEZE_POST = 2,
    parameter int MAX_READS   = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic [NCH-1:0]       TOKEN,
    input  logic                 FIFO_NEAR_FULL,
    input  logic                 CLR_ERR,
    output logic [NCH-1:0]       READ,
    output logic [NCH-1:0]       FREEZE,
    output logic [NCH-1:0]       GRANT,
    output logic                 BUSY,
    output logic                 TIMEOUT_ERR,
    output logic [NCH*CNT_W-1:0] BURST_CNT
);

    localparam int IDX_W = idx_w(NCH);

    localparam logic [PHASE_W-1:0] PRE_LAST  = PHASE_W'(FREEZE_PRE - 1);
    localparam logic [PHASE_W-1:0] HI_LAST   = PHASE_W'(READ_HI - 1);
    localparam logic [PHASE_W-1:0] LO_LAST   = PHASE_W'(READ_LO - 1);
    localparam logic [PHASE_W-1:0] POST_LAST = PHASE_W'(FREEZE_POST);
    localparam logic [CNT_W-1:0]   MAX_RD    = CNT_W'(MAX_READS);
    localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

    logic [NCH-1:0]     tok_meta_q;
    logic [NCH-1:0]     tok_s_q;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   rdcnt_q, rdcnt_d;
    logic               err_q, err_d;
    logic [NCH-1:0]     read_q, read_d;
    logic [NCH-1:0]     freeze_q, freeze_d;
    logic [NCH-1:0]     grant_q, grant_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_sel;
    logic               burst_done;
    logic [NCH-1:0]     sel_oh;
    logic               hold_d;

    // TOKEN is asynchronous to CLK; only tok_s_q is ever used for decisions.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tok_meta_q <= '0;
            tok_s_q    <= '0;
        end else begin
            tok_meta_q <= TOKEN;
            tok_s_q    <= tok_meta_q;
        end
    end

    rr_pick #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (tok_s_q),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        rdcnt_d    = rdcnt_q;
        err_d      = err_q;
        burst_done = 1'b0;

        // A timeout set later in this block overrides a same-cycle clear.
        if (CLR_ERR) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ENABLE && !FIFO_NEAR_FULL && pick_valid) begin
                    state_d = PRE;
                    phase_d = '0;
                    sel_d   = pick_sel;
                    ptr_d   = pick_sel;
                end
            end
            PRE: begin
                if (phase_q == PRE_LAST) begin
                    state_d = RD_HI;
                    phase_d = '0;
                    rdcnt_d = (rdcnt_q == CNT_SAT) ? rdcnt_q : rdcnt_q + 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RD_HI: begin
                if (phase_q == HI_LAST) begin
                    state_d = RD_LO;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RD_LO: begin
                if (phase_q >= LO_LAST) begin
                    if (!tok_s_q[sel_q]) begin
                        state_d = POST;
                        phase_d = '0;
                    end else if (rdcnt_q == MAX_RD) begin
                        err_d   = 1'b1;
                        state_d = POST;
                        phase_d = '0;
                    end else if (!FIFO_NEAR_FULL) begin
                        state_d = RD_HI;
                        phase_d = '0;
                        rdcnt_d = (rdcnt_q == CNT_SAT) ? rdcnt_q : rdcnt_q + 1'b1;
                    end
                    // Near-full: park here with READ low, phase held at its end.
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            POST: begin
                if (phase_q == POST_LAST) begin
                    state_d    = IDLE;
                    phase_d    = '0;
                    rdcnt_d    = '0;
                    burst_done = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes from a flop.
    always_comb begin
        sel_oh   = NCH'(1) << sel_d;
        hold_d   = (state_d == PRE) || (state_d == RD_HI) || (state_d == RD_LO) ||
                   ((state_d == POST) && (phase_d != POST_LAST));
        grant_d  = hold_d ? sel_oh : '0;
        freeze_d = hold_d ? sel_oh : '0;
        read_d   = (state_d == RD_HI) ? sel_oh : '0;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            sel_q    <= '0;
            ptr_q    <= IDX_W'(NCH - 1);
            rdcnt_q  <= '0;
            err_q    <= 1'b0;
            read_q   <= '0;
            freeze_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            rdcnt_q  <= rdcnt_d;
            err_q    <= err_d;
            read_q   <= read_d;
            freeze_q <= freeze_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign READ        = read_q;
    assign FREEZE      = freeze_q;
    assign GRANT       = grant_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = err_q;

`ifdef TJMONO_RO_SCHED_STATS_EN
    generate
        for (genvar g = 0; g < NCH; g++) begin : g_stats
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (burst_done && (sel_q == IDX_W'(g)) && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign BURST_CNT[g*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`else
    logic unused_burst_done;
    assign unused_burst_done = burst_done;
    assign BURST_CNT         = '0;
`endif

endmodule
`default_nettype wire
